// File: rtl/frq_pkg.sv
// Shared types and constants for the mclk-domain tick controller.
// Holds the FSM state type, default rates and the scan_sel width helper.
package frq_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam int unsigned DEF_DIV  = 100_000_000;
    localparam int unsigned SCAN_DIV = 100_000;
    localparam int unsigned DIGITS   = 4;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Generic clock-enable divider: counts 0..div-1 while enabled.
// A divisor of 0 behaves as 1; tc is a registered one-cycle wrap pulse.
module tick_div
    import frq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         wrap,
    output logic         tc
);

    logic [W-1:0] cnt;
    logic [W-1:0] last_val;

    assign last_val = (div == '0) ? '0 : div - 1'b1;
    assign wrap     = en && !clr && (cnt >= last_val);

    // Advance the counter, wrap at the terminal count and flag the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else begin
            tc <= wrap;
            if (wrap) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frq_tick_ctrl.sv
// Count/scan tick generator for the BCD counter and 7-segment display.
// Run/stop/step control plus glitch-free divisor reload with ack.
module frq_tick_ctrl
    import frq_pkg::*;
#(
    parameter int unsigned DIV_W    = 27,
    parameter int unsigned DEF_DIV  = frq_pkg::DEF_DIV,
    parameter int unsigned SCAN_DIV = frq_pkg::SCAN_DIV,
    parameter int unsigned DIGITS   = frq_pkg::DIGITS,
    localparam int SEL_W = sel_w(DIGITS)
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_ld,
    output logic             div_ack,
    output logic             cnt_tick,
    output logic             scan_tick,
    output logic [SEL_W-1:0] scan_sel,
    output logic             running
);

    localparam logic [DIV_W-1:0] DEF_V  = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] SCAN_V = DIV_W'(SCAN_DIV);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

    state_t           state;
    logic             step_tick;
    logic             run_go;
    logic             cnt_wrap;
    logic             cnt_tc;
    logic             scan_wrap;
    logic             pend;
    logic [DIV_W-1:0] pend_val;
    logic [DIV_W-1:0] div_reg;

    // Counting only while RUN is held; dropping run clears the phase.
    assign run_go   = (state == RUN) && run;
    assign cnt_tick = cnt_tc || step_tick;

    tick_div #(.W(DIV_W)) u_cnt (
        .clk   (mclk),
        .rst_n (rst_n),
        .en    (run_go),
        .clr   (!run_go),
        .div   (div_reg),
        .wrap  (cnt_wrap),
        .tc    (cnt_tc)
    );

    tick_div #(.W(DIV_W)) u_scan (
        .clk   (mclk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .div   (SCAN_V),
        .wrap  (scan_wrap),
        .tc    (scan_tick)
    );

    // Run/stop/step FSM with registered running and step tick.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state     <= STOP;
            running   <= 1'b0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            unique case (state)
                STOP: begin
                    if (run) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (step) begin
                        state     <= STEP;
                        step_tick <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state   <= STOP;
                        running <= 1'b0;
                    end
                end
                STEP: begin
                    state   <= run ? RUN : STOP;
                    running <= run;
                end
                default: begin
                    state   <= STOP;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Divisor reload: a fresh request always overwrites and defers.
    // Applied at once when idle, or only at a wrap while running.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            div_reg  <= DEF_V;
            pend     <= 1'b0;
            pend_val <= '0;
            div_ack  <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            if (div_ld) begin
                pend     <= 1'b1;
                pend_val <= div_val;
            end else if (pend && (state != RUN || cnt_wrap)) begin
                div_reg <= pend_val;
                pend    <= 1'b0;
                div_ack <= 1'b1;
            end
        end
    end

    // Digit select steps together with each scan tick.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            scan_sel <= '0;
        end else if (scan_wrap) begin
            scan_sel <= (scan_sel == SEL_LAST) ? '0 : scan_sel + 1'b1;
        end
    end

endmodule

// File: tb/tb_frq_tick_ctrl.sv
// Self-checking bench for frq_tick_ctrl with a schedule-based model.
// Directed steps from the test plan followed by a random phase.
module tb_frq_tick_ctrl;

    localparam int DIV_W    = 27;
    localparam int DEF_DIV  = 10;
    localparam int SCAN_DIV = 4;
    localparam int DIGITS   = 4;

    logic             mclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             div_ld = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             div_ack;
    logic             cnt_tick;
    logic             scan_tick;
    logic [1:0]       scan_sel;
    logic             running;

    int errors = 0;
    int checks = 0;

    // Model: absolute edge numbers and a scheduled next tick time.
    int  n;
    int  e;
    int  next_tick;
    int  m_div;
    int  m_pval;
    bit  m_run;
    bit  m_step;
    bit  m_pend;
    bit  x_tick;
    bit  x_ack;
    bit  x_scan;
    int  x_sel;

    frq_tick_ctrl #(
        .DIV_W    (DIV_W),
        .DEF_DIV  (DEF_DIV),
        .SCAN_DIV (SCAN_DIV),
        .DIGITS   (DIGITS)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .run       (run),
        .step      (step),
        .div_val   (div_val),
        .div_ld    (div_ld),
        .div_ack   (div_ack),
        .cnt_tick  (cnt_tick),
        .scan_tick (scan_tick),
        .scan_sel  (scan_sel),
        .running   (running)
    );

    always #5 mclk = ~mclk;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Predict outputs after the coming edge from the current inputs.
    task automatic model_edge();
        x_tick = 1'b0;
        x_ack  = 1'b0;
        if (!rst_n) begin
            n = 0; e = 0;
            m_run = 0; m_step = 0; m_pend = 0;
            m_div = DEF_DIV;
            x_scan = 0; x_sel = 0;
        end else begin
            n++;
            e++;
            x_scan = (e % SCAN_DIV) == 0;
            x_sel  = (e / SCAN_DIV) % DIGITS;
            if (m_run) begin
                if (!run) begin
                    m_run = 0;
                end else if (n == next_tick) begin
                    x_tick = 1'b1;
                    if (m_pend && !div_ld) begin
                        m_div = m_pval; m_pend = 0; x_ack = 1'b1;
                    end
                    next_tick = n + eff(m_div);
                end
            end else begin
                if (m_pend && !div_ld) begin
                    m_div = m_pval; m_pend = 0; x_ack = 1'b1;
                end
                if (m_step) begin
                    m_step = 0;
                    if (run) begin
                        m_run = 1; next_tick = n + eff(m_div);
                    end
                end else if (run) begin
                    m_run = 1; next_tick = n + eff(m_div);
                end else if (step) begin
                    m_step = 1; x_tick = 1'b1;
                end
            end
            if (div_ld) begin
                m_pend = 1; m_pval = int'(div_val);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge mclk);
        #1;
        check("cnt_tick", cnt_tick, x_tick);
        check("div_ack", div_ack, x_ack);
        check("scan_tick", scan_tick, x_scan);
        check("scan_sel", scan_sel, x_sel);
        check("running", running, m_run);
    endtask

    task automatic wait_tick(input int limit, output int cyc);
        bit done;
        done = 0;
        cyc  = 0;
        for (int i = 0; i < limit && !done; i++) begin
            tick();
            cyc++;
            if (cnt_tick === 1'b1) done = 1;
        end
        if (!done) cyc = -1;
    endtask

    initial begin
        int c;
        int acks;

        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_running", running, 0);
        check("rst_scan_sel", scan_sel, 0);
        rst_n = 1'b1;

        // Free run at the default divisor
        run = 1'b1;
        tick();
        check("run_rise", running, 1);
        wait_tick(40, c);
        check("first_period", c, 10);
        wait_tick(40, c);
        check("second_period", c, 10);

        // Stop mid-period, then single step
        repeat (6) tick();
        run = 1'b0;
        tick();
        check("stop_no_tick", cnt_tick, 0);
        repeat (3) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_tick", cnt_tick, 1);
        check("step_not_running", running, 0);
        tick();
        check("step_one_only", cnt_tick, 0);

        // Reload while running: current period completes first
        run = 1'b1;
        tick();
        repeat (3) tick();
        div_val = 5;
        div_ld  = 1'b1;
        tick();
        div_ld = 1'b0;
        wait_tick(40, c);
        check("reload_rest", c, 6);
        check("reload_ack", div_ack, 1);
        wait_tick(40, c);
        check("reload_period", c, 5);

        // Back-to-back loads while stopped give a single ack
        run = 1'b0;
        repeat (2) tick();
        div_val = 7;
        div_ld  = 1'b1;
        tick();
        div_val = 3;
        tick();
        div_ld = 1'b0;
        acks = 0;
        repeat (4) begin
            tick();
            if (div_ack === 1'b1) acks++;
        end
        check("single_ack", acks, 1);
        run = 1'b1;
        tick();
        wait_tick(40, c);
        check("period_3", c, 3);

        // Divisor 0 clamps to a tick every cycle
        run = 1'b0;
        tick();
        div_val = 0;
        div_ld  = 1'b1;
        tick();
        div_ld = 1'b0;
        tick();
        run = 1'b1;
        tick();
        repeat (6) begin
            tick();
            check("div0_tick", cnt_tick, 1);
        end

        // Reset during a pending load discards it
        run = 1'b0;
        tick();
        div_val = 9;
        div_ld  = 1'b1;
        tick();
        div_ld = 1'b0;
        rst_n  = 1'b0;
        tick();
        check("rst_no_ack", div_ack, 0);
        check("rst_cnt_tick", cnt_tick, 0);
        check("rst_sel", scan_sel, 0);
        rst_n = 1'b1;
        run   = 1'b1;
        tick();
        wait_tick(40, c);
        check("rst_div_back", c, 10);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) run = ~run;
            step   = ($urandom_range(7) == 0);
            div_ld = ($urandom_range(15) == 0);
            div_val = DIV_W'($urandom_range(12));
            rst_n  = ($urandom_range(499) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frq_tick_ctrl.md
Name: frq_tick_ctrl

Overview:
- Controls the timing that drives the BCD counter / 7-segment display path.
- Replaces the free-running frq_div clock output with synchronous clock-enable ticks, all in the mclk domain.
- Generates a programmable count tick for the BCD counter, with run, stop and single-step control.
- Generates a fixed-rate scan tick and a digit-select sequence for display multiplexing.
- Accepts divisor reloads through a load/acknowledge handshake that never produces a short or glitched period.

Parameters:
- DIV_W, 27, width of the count divisor and count counter.
- DEF_DIV, 100_000_000, count divisor loaded at reset (1 Hz at 100 MHz).
- SCAN_DIV, 100_000, scan period in mclk cycles (fixed).
- DIGITS, 4, number of display digits; scan_sel wraps at DIGITS-1.

Ports:
- mclk, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: synchronous active-low reset.
- run, input, 1: level; 1 = free-run count ticks, 0 = stop.
- step, input, 1: single-cycle pulse; requests exactly one count tick while stopped.
- div_val, input, DIV_W: new count divisor.
- div_ld, input, 1: pulse; requests a load of div_val.
- div_ack, output, 1: one-cycle pulse when the new divisor takes effect.
- cnt_tick, output, 1: one-cycle count enable for the BCD counter.
- scan_tick, output, 1: one-cycle display scan enable.
- scan_sel, output, clog2(DIGITS): active digit index.
- running, output, 1: 1 while the FSM is in RUN.

Behaviour:
- Clock and reset:
  - One clock (mclk); reset is synchronous and active-low (rst_n).
  - While rst_n=0 at an mclk edge:
    - div_reg=DEF_DIV; count counter=0; scan counter=0.
    - scan_sel=0; cnt_tick, scan_tick, div_ack and running all 0.
    - Pending-load flag cleared; FSM in STOP.
  - A reset asserted mid-period or mid-load discards any pending divisor; div_ack does not pulse.
- FSM states: STOP, RUN, STEP.
  - STOP: if run=1, go to RUN. Else if step=1, go to STEP. run has priority over a simultaneous step.
  - RUN: if run=0, go to STOP and clear the count counter to 0; no tick is emitted on that edge.
  - STEP: lasts exactly one cycle with cnt_tick=1, then returns to STOP (or RUN if run=1).
  - step is ignored outside STOP.
- Count path (RUN only):
  - Counter runs 0..div_reg-1.
  - On the edge where counter==div_reg-1, the counter wraps to 0 and cnt_tick is registered 1 for the next cycle.
  - Period is exactly div_reg cycles.
  - The first tick after STOP->RUN occurs div_reg cycles after running rises.
  - Effective divisor 0 is clamped to 1, giving cnt_tick high every cycle in RUN.
- Divisor load:
  - div_val is captured into a pending register on any cycle with div_ld=1.
  - If the FSM is not RUN, the pending value is applied on the next edge and div_ack pulses the cycle after capture.
  - If the FSM is RUN, the load is applied on the terminal-count edge, together with the wrap, and div_ack pulses coincident with that cnt_tick.
  - A second div_ld before application overwrites the pending value and yields only one ack.
  - A div_ld coincident with the terminal count is applied at the following wrap, not the current one.
- Scan path:
  - Always free-running, independent of FSM state, so the display refreshes while stopped.
  - Scan counter runs 0..SCAN_DIV-1; scan_tick is a one-cycle pulse per period.
  - scan_sel increments on the edge where scan_tick is registered 1 and wraps DIGITS-1 -> 0.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Package frq_pkg:
  - State enum {STOP, RUN, STEP}.
  - Constants DEF_DIV, SCAN_DIV, DIGITS.
  - Function for the scan_sel width.
- Sub-module tick_div: generic counter with divisor input, enable, sync clear and registered terminal-count pulse.
  - Instantiated twice: count path with enable=running, scan path with enable=1 and constant divisor.

Test Plan (DEF_DIV=10, SCAN_DIV=4, DIGITS=4):
- Reset, then run=1 held -> running=1 next cycle; cnt_tick every 10 cycles, first 10 cycles after running rises; scan_tick every 4 cycles; scan_sel 0,1,2,3,0.
- run=0 mid-period (counter=6), then step pulse -> no tick on stop; exactly one cnt_tick one cycle after step; running stays 0.
- In RUN, div_ld with div_val=5 at counter=3 -> current period completes at 10; div_ack coincides with that cnt_tick; following periods are 5.
- In STOP, div_ld 7 then div_ld 3 on consecutive cycles -> single div_ack; next RUN period is 3.
- div_val=0 loaded, run=1 -> cnt_tick high every cycle; scan path unaffected.
- rst_n=0 during a pending load -> no div_ack; divisor back to 10; all outputs 0, scan_sel=0.
